// File: rtl/serial_regfile_pkg.sv
// Shared opcodes, FSM state type and frame sizing helper for the byte-serial
// register file controller.
package serial_regfile_pkg;

  localparam logic [2:0] OP_NOP       = 3'b000;
  localparam logic [2:0] OP_SHIFT     = 3'b001;
  localparam logic [2:0] OP_WRITE     = 3'b010;
  localparam logic [2:0] OP_READ      = 3'b011;
  localparam logic [2:0] OP_WRITE_INC = 3'b100;
  localparam logic [2:0] OP_READ_INC  = 3'b101;
  localparam logic [2:0] OP_CLEAR     = 3'b110;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } state_t;

  // Number of serial bytes needed to fill a frame of frame_w bits.
  function automatic int calc_nbytes(input int frame_w, input int byte_w);
    return (frame_w + byte_w - 1) / byte_w;
  endfunction

endpackage

// File: rtl/serial_regfile_ctrl_rf_mem.sv
// Register array: one synchronous write port, one synchronous read port, no
// reset so it can map onto SRAM macros or plain flops.
module rf_mem #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rd_q_r;

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port; holds its value when not enabled.
  always_ff @(posedge clk) begin
    if (re) begin
      rd_q_r <= mem_r[raddr];
    end
  end

  assign rdata = rd_q_r;

endmodule

// File: rtl/serial_regfile_ctrl.sv
// Byte-serial frame controller: loads a {data, address} frame one byte at a
// time and moves the data field to/from the register array.
module serial_regfile_ctrl
  import serial_regfile_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [2:0]        cmd_op,
  output logic              cmd_ready,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout,
  output logic              frame_full,
  output logic              rd_done
);

  localparam int FRAME_W = DATA_W + ADDR_W;
  localparam int NBYTES  = calc_nbytes(FRAME_W, BYTE_W);
  localparam int CNT_W   = $clog2(NBYTES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NBYTES);

  logic [FRAME_W-1:0] frame_r;
  logic [CNT_W-1:0]   byte_cnt_r;
  state_t             state_r;
  logic               inc_r;
  logic               rd_done_r;

  logic               cmd_ready_s;
  logic               cmd_fire_s;
  logic               wr_en_s;
  logic               rd_en_s;
  logic [ADDR_W-1:0]  addr_s;
  logic [ADDR_W-1:0]  addr_inc_s;
  logic [DATA_W-1:0]  data_s;
  logic [DATA_W-1:0]  rd_q_s;

  assign cmd_ready_s = (state_r == ST_IDLE);
  assign cmd_fire_s  = cmd_valid & cmd_ready_s;
  assign addr_s      = frame_r[ADDR_W-1:0];
  assign data_s      = frame_r[FRAME_W-1:ADDR_W];
  assign addr_inc_s  = addr_s + {{(ADDR_W-1){1'b0}}, 1'b1};

  // Array port enables for the accepted command.
  always_comb begin
    wr_en_s = 1'b0;
    rd_en_s = 1'b0;
    if (cmd_fire_s) begin
      case (cmd_op)
        OP_WRITE, OP_WRITE_INC: wr_en_s = 1'b1;
        OP_READ, OP_READ_INC:   rd_en_s = 1'b1;
        default: begin
          wr_en_s = 1'b0;
          rd_en_s = 1'b0;
        end
      endcase
    end else begin
      wr_en_s = 1'b0;
      rd_en_s = 1'b0;
    end
  end

  rf_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rf_mem (
    .clk   (clk),
    .we    (wr_en_s),
    .waddr (addr_s),
    .wdata (data_s),
    .re    (rd_en_s),
    .raddr (addr_s),
    .rdata (rd_q_s)
  );

  // Frame, byte counter and read-wait FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_r    <= '0;
      byte_cnt_r <= '0;
      state_r    <= ST_IDLE;
      inc_r      <= 1'b0;
      rd_done_r  <= 1'b0;
    end else begin
      rd_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cmd_fire_s) begin
            case (cmd_op)
              OP_SHIFT: begin
                frame_r <= {frame_r[FRAME_W-BYTE_W-1:0], din};
                if (byte_cnt_r != CNT_MAX) begin
                  byte_cnt_r <= byte_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
              end
              OP_WRITE_INC: frame_r[ADDR_W-1:0] <= addr_inc_s;
              OP_READ, OP_READ_INC: begin
                state_r <= ST_RD_WAIT;
                inc_r   <= (cmd_op == OP_READ_INC);
              end
              OP_CLEAR: begin
                frame_r    <= '0;
                byte_cnt_r <= '0;
              end
              default: ;
            endcase
          end
        end
        ST_RD_WAIT: begin
          // Array output is valid one edge after the read was accepted.
          frame_r[FRAME_W-1:ADDR_W] <= rd_q_s;
          if (inc_r) begin
            frame_r[ADDR_W-1:0] <= addr_inc_s;
          end
          rd_done_r <= 1'b1;
          state_r   <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign dout       = frame_r[FRAME_W-1 -: BYTE_W];
  assign frame_full = (byte_cnt_r == CNT_MAX);
  assign cmd_ready  = cmd_ready_s;
  assign rd_done    = rd_done_r;

endmodule

// File: tb/tb_serial_regfile_ctrl.sv
// Self-checking bench for serial_regfile_ctrl: directed test-plan sequences
// plus random commands, all checked against a behavioural frame/array model.
module tb_serial_regfile_ctrl;

  localparam int DATA_W  = 64;
  localparam int ADDR_W  = 5;
  localparam int BYTE_W  = 8;
  localparam int FRAME_W = DATA_W + ADDR_W;
  localparam int NBYTES  = (FRAME_W + BYTE_W - 1) / BYTE_W;
  localparam int DEPTH   = 2 ** ADDR_W;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic [2:0]        cmd_op;
  logic              cmd_ready;
  logic [BYTE_W-1:0] din;
  logic [BYTE_W-1:0] dout;
  logic              frame_full;
  logic              rd_done;

  int checks = 0;
  int errors = 0;

  serial_regfile_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYTE_W (BYTE_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_ready  (cmd_ready),
    .din        (din),
    .dout       (dout),
    .frame_full (frame_full),
    .rd_done    (rd_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [FRAME_W-1:0] m_frame;
  int                 m_cnt;
  bit                 m_wait;
  bit                 m_inc;
  bit                 m_rd_done;
  bit                 m_valid = 1'b0;
  logic [DATA_W-1:0]  m_pend;
  logic [DATA_W-1:0]  m_mem [DEPTH];

  function automatic int addr_of(input logic [FRAME_W-1:0] f);
    return int'(f % FRAME_W'(DEPTH));
  endfunction

  function automatic logic [DATA_W-1:0] data_of(input logic [FRAME_W-1:0] f);
    return DATA_W'(f >> ADDR_W);
  endfunction

  function automatic logic [FRAME_W-1:0] build(input logic [DATA_W-1:0] d, input int a);
    return (FRAME_W'(d) << ADDR_W) + FRAME_W'(a);
  endfunction

  always @(posedge clk) begin : model
    logic [FRAME_W-1:0] f;
    int c;
    bit w, inc, rd;
    if (rst) begin
      m_frame   <= '0;
      m_cnt     <= 0;
      m_wait    <= 1'b0;
      m_inc     <= 1'b0;
      m_rd_done <= 1'b0;
      m_valid   <= 1'b1;
    end else if (m_valid) begin
      f = m_frame; c = m_cnt; w = m_wait; inc = m_inc; rd = 1'b0;
      if (m_wait) begin
        f  = build(m_pend, inc ? (addr_of(f) + 1) % DEPTH : addr_of(f));
        w  = 1'b0;
        rd = 1'b1;
      end else if (cmd_valid) begin
        case (cmd_op)
          3'd1: begin
            f = (f << BYTE_W) | FRAME_W'(din);
            c = (c < NBYTES) ? c + 1 : NBYTES;
          end
          3'd2: m_mem[addr_of(f)] <= data_of(f);
          3'd3, 3'd5: begin
            m_pend <= m_mem[addr_of(f)];
            w   = 1'b1;
            inc = (cmd_op == 3'd5);
          end
          3'd4: begin
            m_mem[addr_of(f)] <= data_of(f);
            f = build(data_of(f), (addr_of(f) + 1) % DEPTH);
          end
          3'd6: begin
            f = '0;
            c = 0;
          end
          default: ;
        endcase
      end
      m_frame   <= f;
      m_cnt     <= c;
      m_wait    <= w;
      m_inc     <= inc;
      m_rd_done <= rd;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("cmp_dout",       64'(dout),       64'(BYTE_W'(m_frame >> (FRAME_W - BYTE_W))));
      chk("cmp_frame_full", 64'(frame_full), 64'(m_cnt == NBYTES));
      chk("cmp_cmd_ready",  64'(cmd_ready),  64'(!m_wait));
      chk("cmp_rd_done",    64'(rd_done),    64'(m_rd_done));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic [2:0] op, input logic [BYTE_W-1:0] d);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    din       = d;
    n = 0;
    while (!cmd_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: cmd_ready got 0 expected 1 for op %0d", op);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic shift_frame(input logic [FRAME_W-1:0] f);
    logic [NBYTES*BYTE_W-1:0] v;
    v = (NBYTES*BYTE_W)'(f);
    for (int i = NBYTES - 1; i >= 0; i--) issue(3'd1, v[i*BYTE_W +: BYTE_W]);
  endtask

  task automatic shift_seq();
    for (int i = 1; i <= 9; i++) issue(3'd1, BYTE_W'(i));
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; din = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_dout", 64'(dout), 64'h00);
    chk("reset_frame_full", 64'(frame_full), 64'h0);
    chk("reset_cmd_ready", 64'(cmd_ready), 64'h1);
    chk("reset_rd_done", 64'(rd_done), 64'h0);

    // Put a known value in every entry and wrap the address back to 0.
    issue(3'd6, 8'h00);
    for (int i = 0; i < DEPTH; i++) issue(3'd4, 8'h00);
    idle(2);
    chk("init_wrap_addr", 64'(addr_of(m_frame)), 64'd0);

    // Nine-byte load and a saturating tenth byte.
    issue(3'd6, 8'h00);
    shift_seq();
    idle(1);
    chk("load_dout", 64'(dout), 64'h08);
    chk("load_full", 64'(frame_full), 64'h1);
    chk("load_model_data", data_of(m_frame), 64'h0810182028303840);
    chk("load_model_addr", 64'(addr_of(m_frame)), 64'd9);
    issue(3'd1, 8'hAA);
    idle(1);
    chk("shift10_dout", 64'(dout), 64'h10);
    chk("shift10_full", 64'(frame_full), 64'h1);

    // WRITE, CLEAR, SHIFT 0x09, READ.
    issue(3'd6, 8'h00);
    shift_seq();
    issue(3'd2, 8'h00);
    issue(3'd6, 8'h00);
    issue(3'd1, 8'h09);
    issue(3'd3, 8'h00);
    @(negedge clk);
    chk("read_stall_ready", 64'(cmd_ready), 64'h0);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("read_rd_done", 64'(rd_done), 64'h1);
    chk("read_dout", 64'(dout), 64'h08);
    chk("read_full", 64'(frame_full), 64'h0);
    chk("read_model_data", data_of(m_frame), 64'h0810182028303840);
    @(negedge clk);
    chk("read_rd_done_once", 64'(rd_done), 64'h0);

    // Auto-increment with wrap.
    issue(3'd6, 8'h00);
    shift_frame(build(64'h1111111111111111, 31));
    issue(3'd4, 8'h00);
    shift_frame(build(64'h2222222222222222, 0));
    issue(3'd4, 8'h00);
    issue(3'd6, 8'h00);
    issue(3'd1, 8'h1F);
    issue(3'd5, 8'h00);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("inc_first_dout", 64'(dout), 64'h11);
    issue(3'd5, 8'h00);
    idle(3);
    chk("inc_dout", 64'(dout), 64'h22);
    chk("inc_model_data", data_of(m_frame), 64'h2222222222222222);
    chk("inc_model_addr", 64'(addr_of(m_frame)), 64'd1);

    // Write then immediate read of the same address, then a stalled SHIFT.
    shift_frame(build(64'hDEADBEEFCAFEF00D, 7));
    issue(3'd2, 8'h00);
    issue(3'd3, 8'h00);
    idle(3);
    chk("raw_dout", 64'(dout), 64'hDE);
    issue(3'd3, 8'h00);
    issue(3'd1, 8'h5A);
    idle(2);
    chk("stall_shift_dout", 64'(dout), 64'hAD);
    chk("stall_shift_full", 64'(frame_full), 64'h1);

    // Reset during RD_WAIT aborts the read.
    issue(3'd3, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rstrd_ready", 64'(cmd_ready), 64'h1);
    chk("rstrd_rd_done", 64'(rd_done), 64'h0);
    chk("rstrd_dout", 64'(dout), 64'h00);
    @(negedge clk);
    chk("rstrd_rd_done_after", 64'(rd_done), 64'h0);

    // Opcode 111 changes nothing.
    shift_seq();
    issue(3'd7, 8'h00);
    idle(2);
    chk("op7_dout", 64'(dout), 64'h08);
    chk("op7_full", 64'(frame_full), 64'h1);

    // Random traffic, including stalls and occasional resets.
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 63) == 0);
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_op    = 3'($urandom_range(0, 7));
      din       = BYTE_W'($urandom);
    end
    @(negedge clk);
    rst = 1'b0;
    cmd_valid = 1'b0;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
